// File: rtl/ibuffer.sv
// Instruction queue between fetch and decode.
// Circular FIFO of {inst, addr}; flush drops all queued entries.
module ibuffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2,
  parameter int WORD  = 32,
  parameter int ADDR  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] addr_i,
  output logic            stall_o,
  input  logic            flush_i,
  output logic            v_o,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] addr_o,
  input  logic            stall_i,
  output logic [PTRW:0]   count_o
);

  typedef struct packed {
    logic [WORD-1:0] inst;
    logic [ADDR-1:0] addr;
  } ent_t;

  localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

  ent_t            mem_q [DEPTH];
  logic [PTRW-1:0] wp_q, wp_d;
  logic [PTRW-1:0] rp_q, rp_d;
  logic [PTRW:0]   cnt_q, cnt_d;
  logic            enq, deq;

  assign stall_o = (cnt_q == FULL);
  assign v_o     = (cnt_q != '0);
  assign inst_o  = mem_q[rp_q].inst;
  assign addr_o  = mem_q[rp_q].addr;
  assign count_o = cnt_q;

  assign enq = v_i & ~stall_o & ~flush_i;
  assign deq = v_o & ~stall_i & ~flush_i;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) wp_d = wp_q + 1'b1;
      if (deq) rp_d = rp_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is left intact on flush; only pointers reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (enq) begin
      mem_q[wp_q] <= '{inst: inst_i, addr: addr_i};
    end
  end

endmodule
